// File: rtl/dmem_ctrl.sv
// dmem_ctrl: data-memory controller between the mem stage and the data bus.
// Stores are posted into a small in-order circular buffer and drained over the
// bus one at a time. A single pending load is held until every older store has
// drained, then issued as a read. The aligned 16-bit field is returned as a
// one-cycle hit.
//
// Ports
//   clk, rst_n       : clock; synchronous reset, asserted HIGH
//   r_v, w_v         : one-cycle load / store requests from mem
//   req_adr          : byte address
//   req_data         : store data, already lane-positioned
//   req_strobe       : byte enables
//   hit, mem_res     : load-complete pulse and aligned 16-bit load field
//   wb_full          : store buffer full
//   ovf              : sticky error (store while full, or load while a load is pending)
//   bus_req/we/adr/wdata/be : bus request fields (registered, stable while stalled)
//   bus_gnt          : request accepted this cycle
//   bus_rvalid/rdata : read return, only honoured while waiting for read data
module dmem_ctrl #(
    parameter int XLEN     = 32,
    parameter int WB_DEPTH = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            r_v,
    input  logic            w_v,
    input  logic [XLEN-1:0] req_adr,
    input  logic [XLEN-1:0] req_data,
    input  logic [3:0]      req_strobe,
    output logic            hit,
    output logic [15:0]     mem_res,
    output logic            wb_full,
    output logic            ovf,
    output logic            bus_req,
    output logic            bus_we,
    output logic [XLEN-1:0] bus_adr,
    output logic [XLEN-1:0] bus_wdata,
    output logic [3:0]      bus_be,
    input  logic            bus_gnt,
    input  logic            bus_rvalid,
    input  logic [XLEN-1:0] bus_rdata
);

    localparam int PW = (WB_DEPTH > 1) ? $clog2(WB_DEPTH) : 1;
    localparam int CW = $clog2(WB_DEPTH + 1);
    localparam logic [PW-1:0] LAST_IDX = PW'(WB_DEPTH - 1);
    localparam logic [CW-1:0] DEPTH_C  = CW'(WB_DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_WRITE     = 2'd1,
        ST_READ_REQ  = 2'd2,
        ST_READ_WAIT = 2'd3
    } state_t;

    state_t          state_r, state_nx_s;

    logic [XLEN-1:0] wb_adr_r  [WB_DEPTH];
    logic [XLEN-1:0] wb_data_r [WB_DEPTH];
    logic [3:0]      wb_be_r   [WB_DEPTH];
    logic [PW-1:0]   head_r, tail_r;
    logic [CW-1:0]   count_r, count_nx_s;
    logic            wb_full_r;

    logic            load_pend_r;
    logic [XLEN-1:0] ld_adr_r;
    logic [3:0]      ld_be_r;

    logic            push_s, pop_s, ld_accept_s, ld_done_s;
    logic [4:0]      sh_s;
    logic [15:0]     ld_field_s;

    logic            hit_r, ovf_r, bus_req_r, bus_we_r;
    logic [15:0]     mem_res_r;
    logic [XLEN-1:0] bus_adr_r, bus_wdata_r;
    logic [3:0]      bus_be_r;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        if (p == LAST_IDX) begin
            return {PW{1'b0}};
        end else begin
            return p + PW'(1);
        end
    endfunction

    // True when exactly one byte lane is enabled (byte access)
    function automatic logic is_single(input logic [3:0] s);
        return (s != 4'b0000) && ((s & (s - 4'b0001)) == 4'b0000);
    endfunction

    assign push_s      = w_v & ~wb_full_r;
    assign pop_s       = (state_r == ST_WRITE) & bus_gnt;
    assign ld_accept_s = r_v & ~load_pend_r;
    assign ld_done_s   = (state_r == ST_READ_WAIT) & bus_rvalid;

    // Buffer occupancy after this cycle's push/pop; simultaneous push and pop cancel
    always_comb begin
        count_nx_s = count_r;
        case ({push_s, pop_s})
            2'b10:   count_nx_s = count_r + CW'(1);
            2'b01:   count_nx_s = count_r - CW'(1);
            default: count_nx_s = count_r;
        endcase
    end

    // Next-state logic: drained stores always win over the pending load
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (count_r != {CW{1'b0}}) begin
                    state_nx_s = ST_WRITE;
                end else if (load_pend_r) begin
                    state_nx_s = ST_READ_REQ;
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            ST_WRITE: begin
                if (bus_gnt) state_nx_s = ST_IDLE;
                else         state_nx_s = ST_WRITE;
            end
            ST_READ_REQ: begin
                if (bus_gnt) state_nx_s = ST_READ_WAIT;
                else         state_nx_s = ST_READ_REQ;
            end
            ST_READ_WAIT: begin
                if (bus_rvalid) state_nx_s = ST_IDLE;
                else            state_nx_s = ST_READ_WAIT;
            end
            default: state_nx_s = ST_IDLE;
        endcase
    end

    // Load field extraction: shift the returned word down to the addressed lane
    always_comb begin
        sh_s = {ld_adr_r[1:0], 3'b000};
        if (is_single(ld_be_r)) begin
            ld_field_s = {8'h00, 8'(bus_rdata >> sh_s)};
        end else begin
            ld_field_s = 16'(bus_rdata >> sh_s);
        end
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst_n) state_r <= ST_IDLE;
        else       state_r <= state_nx_s;
    end

    // Store-buffer payload, written at the tail; contents are don't-care until pushed
    always_ff @(posedge clk) begin
        if (push_s) begin
            wb_adr_r[tail_r]  <= {req_adr[XLEN-1:2], 2'b00};
            wb_data_r[tail_r] <= req_data;
            wb_be_r[tail_r]   <= req_strobe;
        end
    end

    // Store-buffer pointers, occupancy and registered full flag
    always_ff @(posedge clk) begin
        if (rst_n) begin
            head_r    <= {PW{1'b0}};
            tail_r    <= {PW{1'b0}};
            count_r   <= {CW{1'b0}};
            wb_full_r <= 1'b0;
        end else begin
            if (push_s) tail_r <= ptr_inc(tail_r);
            if (pop_s)  head_r <= ptr_inc(head_r);
            count_r   <= count_nx_s;
            wb_full_r <= (count_nx_s == DEPTH_C);
        end
    end

    // Pending-load register; a second load while one is pending is dropped
    always_ff @(posedge clk) begin
        if (rst_n) begin
            load_pend_r <= 1'b0;
            ld_adr_r    <= {XLEN{1'b0}};
            ld_be_r     <= 4'b0000;
        end else if (ld_accept_s) begin
            load_pend_r <= 1'b1;
            ld_adr_r    <= req_adr;
            ld_be_r     <= req_strobe;
        end else if (ld_done_s) begin
            load_pend_r <= 1'b0;
        end
    end

    // Sticky overflow flag
    always_ff @(posedge clk) begin
        if (rst_n) ovf_r <= 1'b0;
        else       ovf_r <= ovf_r | (w_v & wb_full_r) | (r_v & load_pend_r);
    end

    // Registered bus request and load response; fields load only when a request starts
    always_ff @(posedge clk) begin
        if (rst_n) begin
            bus_req_r   <= 1'b0;
            bus_we_r    <= 1'b0;
            bus_adr_r   <= {XLEN{1'b0}};
            bus_wdata_r <= {XLEN{1'b0}};
            bus_be_r    <= 4'b0000;
            hit_r       <= 1'b0;
            mem_res_r   <= 16'h0000;
        end else begin
            hit_r <= ld_done_s;
            if (ld_done_s) mem_res_r <= ld_field_s;
            if ((state_r == ST_IDLE) && (state_nx_s == ST_WRITE)) begin
                bus_req_r   <= 1'b1;
                bus_we_r    <= 1'b1;
                bus_adr_r   <= wb_adr_r[head_r];
                bus_wdata_r <= wb_data_r[head_r];
                bus_be_r    <= wb_be_r[head_r];
            end else if ((state_r == ST_IDLE) && (state_nx_s == ST_READ_REQ)) begin
                bus_req_r   <= 1'b1;
                bus_we_r    <= 1'b0;
                bus_adr_r   <= {ld_adr_r[XLEN-1:2], 2'b00};
                bus_wdata_r <= {XLEN{1'b0}};
                bus_be_r    <= ld_be_r;
            end else if ((state_nx_s == ST_IDLE) || (state_nx_s == ST_READ_WAIT)) begin
                bus_req_r   <= 1'b0;
            end else begin
                bus_req_r   <= bus_req_r;
            end
        end
    end

    assign hit       = hit_r;
    assign mem_res   = mem_res_r;
    assign wb_full   = wb_full_r;
    assign ovf       = ovf_r;
    assign bus_req   = bus_req_r;
    assign bus_we    = bus_we_r;
    assign bus_adr   = bus_adr_r;
    assign bus_wdata = bus_wdata_r;
    assign bus_be    = bus_be_r;

endmodule
